// File: rtl/hpi_pkg.sv
// hpi_pkg: shared FSM state type and counter sizing for the HPI bus master.
package hpi_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} hpi_state_t;

    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/hpi_int_sync.sv
// hpi_int_sync: multi-stage synchroniser for OTG_INT with rising-edge pulse.
module hpi_int_sync #(
    parameter int STAGES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic irq_in,
    output logic level,
    output logic pulse
);

    logic [STAGES-1:0] sr;
    logic              prev;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sr   <= '0;
            prev <= 1'b0;
        end else begin
            sr   <= {sr[STAGES-2:0], irq_in};
            prev <= sr[STAGES-1];
        end
    end

    assign level = sr[STAGES-1];
    assign pulse = level & ~prev;

endmodule

// File: rtl/hpi_bus_master.sv
// hpi_bus_master: self-timed HPI read/write cycle generator with interrupt synchroniser.
module hpi_bus_master
    import hpi_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int INT_SYNC  = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              irq_level,
    output logic              irq_pulse,
    inout  wire  [DATA_W-1:0] OTG_DATA,
    output logic [ADDR_W-1:0] OTG_ADDR,
    output logic              OTG_RD_N,
    output logic              OTG_WR_N,
    output logic              OTG_CS_N,
    output logic              OTG_RST_N,
    input  logic              OTG_INT
);

    localparam int CW = cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);

    if (SETUP_CYC < 1) begin : g_bad_setup
        $error("SETUP_CYC must be at least 1");
    end
    if (PULSE_CYC < 1) begin : g_bad_pulse
        $error("PULSE_CYC must be at least 1");
    end
    if (HOLD_CYC < 0) begin : g_bad_hold
        $error("HOLD_CYC must not be negative");
    end
    if (INT_SYNC < 2) begin : g_bad_sync
        $error("INT_SYNC must be at least 2");
    end

    hpi_state_t        state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic              last;

    assign last = cnt == '0;

    always_comb begin
        state_n = state;
        cnt_n   = cnt - CW'(1);
        case (state)
            IDLE: if (req_valid) begin
                state_n = SETUP;
                cnt_n   = CW'(SETUP_CYC - 1);
            end
            SETUP: if (last) begin
                state_n = STROBE;
                cnt_n   = CW'(PULSE_CYC - 1);
            end
            STROBE: if (last) begin
                state_n = (HOLD_CYC > 0) ? HOLD : DONE;
                cnt_n   = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
            end
            HOLD: if (last) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // Pin strobes are decoded from the next state so they change cleanly on the clock edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            wr        <= 1'b0;
            wdata     <= '0;
            rsp_rdata <= '0;
            OTG_ADDR  <= '0;
            OTG_CS_N  <= 1'b1;
            OTG_RD_N  <= 1'b1;
            OTG_WR_N  <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && req_valid) begin
                wr       <= req_write;
                wdata    <= req_wdata;
                OTG_ADDR <= req_addr;
            end
            if (state == STROBE && last && !wr) rsp_rdata <= OTG_DATA;
            OTG_CS_N <= state_n == IDLE || state_n == DONE;
            OTG_RD_N <= !(state_n == STROBE && !wr);
            OTG_WR_N <= !(state_n == STROBE && wr);
        end
    end

    assign OTG_DATA  = (wr && (state == SETUP || state == STROBE || state == HOLD)) ? wdata : 'z;
    assign req_ready = state == IDLE;
    assign rsp_valid = state == DONE;
    assign OTG_RST_N = ~Reset;

    hpi_int_sync #(.STAGES(INT_SYNC)) u_int_sync (
        .Clk   (Clk),
        .Reset (Reset),
        .irq_in(OTG_INT),
        .level (irq_level),
        .pulse (irq_pulse)
    );

endmodule

// File: tb/tb_hpi_bus_master.sv
// tb_hpi_bus_master: directed checks of HPI cycle timing, reset abort and interrupt sync.
module tb_hpi_bus_master;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_valid2 = 1'b0, req_write = 1'b0;
    logic [1:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        otg_int = 1'b0, tb_en = 1'b1;

    logic        req_ready, rsp_valid, irq_level, irq_pulse;
    logic [15:0] rsp_rdata;
    logic [1:0]  otg_addr;
    logic        otg_rd_n, otg_wr_n, otg_cs_n, otg_rst_n;
    wire  [15:0] otg_data;

    logic        req_ready2, rsp_valid2, irq_level2, irq_pulse2;
    logic [15:0] rsp_rdata2;
    logic [1:0]  otg_addr2;
    logic        otg_rd_n2, otg_wr_n2, otg_cs_n2, otg_rst_n2;
    wire  [15:0] otg_data2;

    int checks = 0, errors = 0;

    // Chip model: returns a fixed word while read-strobed; otherwise the bench may park a marker on the bus.
    assign otg_data  = (!otg_cs_n && !otg_rd_n) ? 16'hBEEF : tb_en ? 16'hA5A5 : 16'hzzzz;
    assign otg_data2 = (!otg_cs_n2 && !otg_rd_n2) ? 16'hC0DE : 16'hzzzz;

    always #5 clk = ~clk;

    hpi_bus_master dut (
        .Clk(clk), .Reset(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .irq_level(irq_level),
        .irq_pulse(irq_pulse), .OTG_DATA(otg_data), .OTG_ADDR(otg_addr),
        .OTG_RD_N(otg_rd_n), .OTG_WR_N(otg_wr_n), .OTG_CS_N(otg_cs_n),
        .OTG_RST_N(otg_rst_n), .OTG_INT(otg_int)
    );

    hpi_bus_master #(.PULSE_CYC(1), .HOLD_CYC(0)) dut2 (
        .Clk(clk), .Reset(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .irq_level(irq_level2),
        .irq_pulse(irq_pulse2), .OTG_DATA(otg_data2), .OTG_ADDR(otg_addr2),
        .OTG_RD_N(otg_rd_n2), .OTG_WR_N(otg_wr_n2), .OTG_CS_N(otg_cs_n2),
        .OTG_RST_N(otg_rst_n2), .OTG_INT(otg_int)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) tick;
        #1;
        checks++;
        if ({req_ready, rsp_valid, irq_level, irq_pulse} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_handshake got %b exp 1000", {req_ready, rsp_valid, irq_level, irq_pulse});
        end
        checks++;
        if ({otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n} !== 4'b1110) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 1110", {otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n});
        end
        checks++;
        if (rsp_rdata !== 16'h0000 || otg_addr !== 2'b00) begin
            errors++;
            $display("FAIL reset_regs rdata %h addr %b exp 0000 00", rsp_rdata, otg_addr);
        end
        checks++;
        if (otg_data !== 16'hA5A5) begin
            errors++;
            $display("FAIL reset_bus_z got %h exp A5A5", otg_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (otg_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL rst_n_release got %b exp 1", otg_rst_n);
        end
    endtask

    task automatic test_reset_mid_write;
        int seen;
        seen = 0;
        tick;
        tb_en = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'b01; req_wdata = 16'h5555;
        tick;
        req_valid = 1'b0;
        tick;
        #1;
        checks++;
        if (otg_wr_n !== 1'b0 || otg_data !== 16'h5555) begin
            errors++;
            $display("FAIL abort_pre_strobe wr_n %b data %h exp 0 5555", otg_wr_n, otg_data);
        end
        rst = 1'b1;
        tb_en = 1'b1;
        #1;
        checks++;
        if ({otg_cs_n, otg_rd_n, otg_wr_n, rsp_valid, req_ready} !== 5'b11101) begin
            errors++;
            $display("FAIL abort_strobes got %b exp 11101", {otg_cs_n, otg_rd_n, otg_wr_n, rsp_valid, req_ready});
        end
        checks++;
        if (otg_data !== 16'hA5A5) begin
            errors++;
            $display("FAIL abort_bus_z got %h exp A5A5", otg_data);
        end
        tick;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_rsp got %0d pulses exp 0", seen);
        end
    endtask

    task automatic test_read;
        tick;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'b10; req_wdata = 16'h0F0F;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_ready0 got %b exp 1", req_ready);
        end
        for (int c = 1; c <= 6; c++) begin
            tick;
            if (c == 1) begin
                req_valid = 1'b0; req_addr = 2'b00; req_write = 1'b1;
            end
            #1;
            checks++;
            if ({otg_cs_n, otg_rd_n, otg_wr_n} !== {!(c >= 1 && c <= 4), !(c >= 2 && c <= 3), 1'b1}) begin
                errors++;
                $display("FAIL read_strobes c=%0d got %b exp %b", c, {otg_cs_n, otg_rd_n, otg_wr_n},
                         {!(c >= 1 && c <= 4), !(c >= 2 && c <= 3), 1'b1});
            end
            checks++;
            if ({rsp_valid, req_ready} !== {c == 5, c == 6}) begin
                errors++;
                $display("FAIL read_handshake c=%0d got %b exp %b", c, {rsp_valid, req_ready}, {c == 5, c == 6});
            end
            if (c <= 5) begin
                checks++;
                if (otg_addr !== 2'b10) begin
                    errors++;
                    $display("FAIL read_addr c=%0d got %b exp 10", c, otg_addr);
                end
            end
            if (c == 5) begin
                checks++;
                if (rsp_rdata !== 16'hBEEF) begin
                    errors++;
                    $display("FAIL read_rdata got %h exp BEEF", rsp_rdata);
                end
            end
        end
    endtask

    task automatic test_write;
        tick;
        tb_en = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'b01; req_wdata = 16'h1234;
        for (int c = 1; c <= 6; c++) begin
            tick;
            if (c == 1) begin
                req_valid = 1'b0; req_wdata = 16'hFFFF;
            end
            if (c == 5) tb_en = 1'b1;
            #1;
            checks++;
            if ({otg_cs_n, otg_rd_n, otg_wr_n} !== {!(c >= 1 && c <= 4), 1'b1, !(c >= 2 && c <= 3)}) begin
                errors++;
                $display("FAIL write_strobes c=%0d got %b exp %b", c, {otg_cs_n, otg_rd_n, otg_wr_n},
                         {!(c >= 1 && c <= 4), 1'b1, !(c >= 2 && c <= 3)});
            end
            checks++;
            if (otg_data !== ((c <= 4) ? 16'h1234 : 16'hA5A5)) begin
                errors++;
                $display("FAIL write_data c=%0d got %h exp %h", c, otg_data, (c <= 4) ? 16'h1234 : 16'hA5A5);
            end
            checks++;
            if ({rsp_valid, req_ready} !== {c == 5, c == 6}) begin
                errors++;
                $display("FAIL write_handshake c=%0d got %b exp %b", c, {rsp_valid, req_ready}, {c == 5, c == 6});
            end
            checks++;
            if (rsp_rdata !== 16'hBEEF) begin
                errors++;
                $display("FAIL write_rdata_kept c=%0d got %h exp BEEF", c, rsp_rdata);
            end
            if (c <= 5) begin
                checks++;
                if (otg_addr !== 2'b01) begin
                    errors++;
                    $display("FAIL write_addr c=%0d got %b exp 01", c, otg_addr);
                end
            end
        end
    endtask

    task automatic test_short;
        tick;
        req_valid2 = 1'b1; req_write = 1'b0; req_addr = 2'b11;
        for (int c = 1; c <= 4; c++) begin
            tick;
            if (c == 1) req_valid2 = 1'b0;
            #1;
            checks++;
            if ({otg_cs_n2, otg_rd_n2, rsp_valid2, req_ready2} !== {!(c <= 2), c != 2, c == 3, c == 4}) begin
                errors++;
                $display("FAIL short_timing c=%0d got %b exp %b", c, {otg_cs_n2, otg_rd_n2, rsp_valid2, req_ready2},
                         {!(c <= 2), c != 2, c == 3, c == 4});
            end
            if (c == 3) begin
                checks++;
                if (rsp_rdata2 !== 16'hC0DE) begin
                    errors++;
                    $display("FAIL short_rdata got %h exp C0DE", rsp_rdata2);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int n, low, rsps;
        int acc [3];
        n = 0; low = 0; rsps = 0;
        acc = '{-100, -100, -100};
        tick;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'b11;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) tick;
            if (n == 3) req_valid = 1'b0;
            #1;
            if (rsp_valid) rsps++;
            if (n >= 1 && n < 3 && !req_ready) low++;
            if (req_valid && req_ready && n < 3) begin
                acc[n] = k;
                n++;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL b2b_count got %0d exp 3", n);
        end
        checks++;
        if (acc[1] - acc[0] !== 6) begin
            errors++;
            $display("FAIL b2b_gap1 got %0d exp 6", acc[1] - acc[0]);
        end
        checks++;
        if (acc[2] - acc[1] !== 6) begin
            errors++;
            $display("FAIL b2b_gap2 got %0d exp 6", acc[2] - acc[1]);
        end
        checks++;
        if (low !== 10) begin
            errors++;
            $display("FAIL b2b_ready_low got %0d exp 10", low);
        end
        checks++;
        if (rsps !== 3) begin
            errors++;
            $display("FAIL b2b_rsps got %0d exp 3", rsps);
        end
    endtask

    task automatic test_irq;
        tick;
        #1;
        checks++;
        if ({irq_level, irq_pulse} !== 2'b00) begin
            errors++;
            $display("FAIL irq_idle got %b exp 00", {irq_level, irq_pulse});
        end
        otg_int = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick;
            if (c == 6) otg_int = 1'b0;
            #1;
            checks++;
            if ({irq_level, irq_pulse} !== {c >= 2 && c <= 7, c == 2}) begin
                errors++;
                $display("FAIL irq c=%0d got %b exp %b", c, {irq_level, irq_pulse}, {c >= 2 && c <= 7, c == 2});
            end
        end
    endtask

    initial begin
        test_reset;
        test_reset_mid_write;
        test_read;
        test_write;
        test_short;
        test_back_to_back;
        test_irq;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
